// File: rtl/conunit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, function codes,
// FSM states, ALU-control and PC-source encodings, and the decoded-instruction record.
package conunit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EXE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic r_add;
    logic r_sub;
    logic r_and;
    logic r_or;
    logic r_slt;
    logic addi;
    logic andi;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic illegal;
  } instr_t;

endpackage

// File: rtl/conunit_decode.sv
// Combinational instruction decoder: Op/Func to one-hot instruction flags,
// with an illegal flag for any encoding outside the supported subset.
module conunit_decode
  import conunit_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  output instr_t     instr
);

  always_comb begin
    instr = '0;
    unique case (Op)
      OP_RTYPE: begin
        unique case (Func)
          FN_ADD:  instr.r_add   = 1'b1;
          FN_SUB:  instr.r_sub   = 1'b1;
          FN_AND:  instr.r_and   = 1'b1;
          FN_OR:   instr.r_or    = 1'b1;
          FN_SLT:  instr.r_slt   = 1'b1;
          default: instr.illegal = 1'b1;
        endcase
      end
      OP_ADDI: instr.addi    = 1'b1;
      OP_ANDI: instr.andi    = 1'b1;
      OP_ORI:  instr.ori     = 1'b1;
      OP_LW:   instr.lw      = 1'b1;
      OP_SW:   instr.sw      = 1'b1;
      OP_BEQ:  instr.beq     = 1'b1;
      OP_BNE:  instr.bne     = 1'b1;
      OP_J:    instr.j       = 1'b1;
      default: instr.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_conunit.sv
// Multi-cycle control FSM: sequences IF/ID/EXE/MEM/WB over a shared memory port,
// traps illegal instructions and counts retired instructions.
module multicycle_conunit
  import conunit_pkg::*;
#(
  parameter int unsigned ALUC_W = 3,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [5:0]        Op,
  input  logic [5:0]        Func,
  input  logic              Z,
  input  logic              Mrdy,
  output logic              Mreq,
  output logic              Msel,
  output logic              Wmem,
  output logic              Irwr,
  output logic              Pcwr,
  output logic [1:0]        Pcsrc,
  output logic              Regrt,
  output logic              Se,
  output logic              Aluqb,
  output logic [ALUC_W-1:0] Aluc,
  output logic              Wreg,
  output logic              Reg2reg,
  output logic              Retire,
  output logic [CNT_W-1:0]  Icnt,
  output logic              Exc
);

  state_t           state, next;
  instr_t           instr;
  logic             rtype;
  logic             branch;
  logic             taken;
  logic [2:0]       alu_code;
  logic [CNT_W-1:0] icnt_q;

  conunit_decode u_decode (
    .Op    (Op),
    .Func  (Func),
    .instr (instr)
  );

  assign rtype  = instr.r_add | instr.r_sub | instr.r_and | instr.r_or | instr.r_slt;
  assign branch = instr.beq | instr.bne;
  assign taken  = (instr.beq & Z) | (instr.bne & ~Z);

  assign alu_code = (instr.r_sub | branch)     ? ALU_SUB :
                    (instr.r_and | instr.andi) ? ALU_AND :
                    (instr.r_or  | instr.ori)  ? ALU_OR  :
                    instr.r_slt                ? ALU_SLT : ALU_ADD;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= S_IF;
      icnt_q <= '0;
    end else begin
      state <= next;
      if (Retire) icnt_q <= icnt_q + CNT_W'(1);
    end
  end

  assign Icnt = Rst ? '0 : icnt_q;

  always_comb begin
    next    = state;
    Mreq    = 1'b0;
    Msel    = 1'b0;
    Wmem    = 1'b0;
    Irwr    = 1'b0;
    Pcwr    = 1'b0;
    Pcsrc   = PC_NEXT;
    Regrt   = 1'b0;
    Se      = 1'b0;
    Aluqb   = 1'b0;
    Aluc    = '0;
    Wreg    = 1'b0;
    Reg2reg = 1'b0;
    Retire  = 1'b0;
    Exc     = 1'b0;
    unique case (state)
      S_IF: begin
        Mreq = 1'b1;
        if (Mrdy) begin
          Irwr = 1'b1;
          Pcwr = 1'b1;
          next = S_ID;
        end
      end
      S_ID: begin
        if (instr.j) begin
          Pcwr   = 1'b1;
          Pcsrc  = PC_JUMP;
          Retire = 1'b1;
          next   = S_IF;
        end else if (instr.illegal) begin
          next = S_TRAP;
        end else begin
          next = S_EXE;
        end
      end
      S_EXE: begin
        Aluc[2:0] = alu_code;
        Aluqb     = rtype | branch;
        Se        = ~(instr.andi | instr.ori);
        if (branch) begin
          Pcwr   = taken;
          Pcsrc  = taken ? PC_BRANCH : PC_NEXT;
          Retire = 1'b1;
          next   = S_IF;
        end else if (instr.lw | instr.sw) begin
          next = S_MEM;
        end else begin
          next = S_WB;
        end
      end
      S_MEM: begin
        Mreq = 1'b1;
        Msel = 1'b1;
        Wmem = instr.sw;
        if (Mrdy) begin
          Retire = instr.sw;
          next   = instr.sw ? S_IF : S_WB;
        end
      end
      S_WB: begin
        Wreg    = 1'b1;
        Regrt   = ~rtype;
        Reg2reg = instr.lw;
        Retire  = 1'b1;
        next    = S_IF;
      end
      S_TRAP: Exc = 1'b1;
      default: next = S_IF;
    endcase
    // Reset overrides everything so a pending fetch or store is dropped in the reset cycle.
    if (Rst) begin
      next    = S_IF;
      Mreq    = 1'b0;
      Msel    = 1'b0;
      Wmem    = 1'b0;
      Irwr    = 1'b0;
      Pcwr    = 1'b0;
      Pcsrc   = PC_NEXT;
      Regrt   = 1'b0;
      Se      = 1'b0;
      Aluqb   = 1'b0;
      Aluc    = '0;
      Wreg    = 1'b0;
      Reg2reg = 1'b0;
      Retire  = 1'b0;
      Exc     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_conunit.sv
// Bench for multicycle_conunit: each instruction is expanded into its expected
// per-cycle output trace from the instruction table, then compared every cycle.
module tb_multicycle_conunit;

  localparam int unsigned ALUC_W = 4;
  localparam int unsigned CNT_W  = 4;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [5:0]        Op = '0;
  logic [5:0]        Func = '0;
  logic              Z = 1'b0;
  logic              Mrdy = 1'b0;
  logic              Mreq, Msel, Wmem, Irwr, Pcwr, Regrt, Se, Aluqb, Wreg, Reg2reg, Retire, Exc;
  logic [1:0]        Pcsrc;
  logic [ALUC_W-1:0] Aluc;
  logic [CNT_W-1:0]  Icnt;

  multicycle_conunit #(.ALUC_W(ALUC_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .Mrdy(Mrdy),
    .Mreq(Mreq), .Msel(Msel), .Wmem(Wmem), .Irwr(Irwr), .Pcwr(Pcwr), .Pcsrc(Pcsrc),
    .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc), .Wreg(Wreg), .Reg2reg(Reg2reg),
    .Retire(Retire), .Icnt(Icnt), .Exc(Exc)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic mreq, msel, wmem, irwr, pcwr;
    logic [1:0] pcsrc;
    logic regrt, se, aluqb;
    logic [ALUC_W-1:0] aluc;
    logic wreg, reg2reg, retire, exc;
  } outs_t;

  typedef struct packed {
    logic legal, rtype, lw, sw, beq, bne, j, imm_zero;
    logic [2:0] aluc;
  } info_t;

  int errors = 0;
  int checks = 0;

  outs_t            act_o, exp_o;
  logic [CNT_W-1:0] exp_icnt;
  logic [CNT_W-1:0] model_cnt = '0;
  logic             exp_valid = 1'b0;
  logic             cur_rst = 1'b1;
  logic [5:0]       cur_op = '0;
  logic [5:0]       cur_func = '0;

  assign act_o = {Mreq, Msel, Wmem, Irwr, Pcwr, Pcsrc, Regrt, Se, Aluqb, Aluc,
                  Wreg, Reg2reg, Retire, Exc};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endfunction

  always @(negedge Clk) begin
    if (exp_valid) begin
      check("outputs", 32'(act_o), 32'(exp_o));
      check("icnt", 32'(Icnt), 32'(exp_icnt));
    end
  end

  // Supported instruction table, written directly from the encoding list.
  function automatic info_t classify(input logic [5:0] op, input logic [5:0] func);
    info_t d = '0;
    d.legal = 1'b1;
    case (op)
      6'h00: begin
        d.rtype = 1'b1;
        case (func)
          6'h20: d.aluc = 3'd0;
          6'h22: d.aluc = 3'd1;
          6'h24: d.aluc = 3'd2;
          6'h25: d.aluc = 3'd3;
          6'h2a: d.aluc = 3'd4;
          default: d.legal = 1'b0;
        endcase
      end
      6'h08: d.aluc = 3'd0;
      6'h0c: begin d.aluc = 3'd2; d.imm_zero = 1'b1; end
      6'h0d: begin d.aluc = 3'd3; d.imm_zero = 1'b1; end
      6'h23: begin d.lw = 1'b1; d.aluc = 3'd0; end
      6'h2b: begin d.sw = 1'b1; d.aluc = 3'd0; end
      6'h04: begin d.beq = 1'b1; d.aluc = 3'd1; end
      6'h05: begin d.bne = 1'b1; d.aluc = 3'd1; end
      6'h02: d.j = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic mrdy, input logic z, input outs_t e);
    @(posedge Clk);
    #1;
    Rst = cur_rst; Op = cur_op; Func = cur_func; Mrdy = mrdy; Z = z;
    exp_o = e; exp_icnt = model_cnt; exp_valid = 1'b1;
    if (e.retire) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic do_reset();
    cur_rst = 1'b1;
    model_cnt = '0;
    step(rb(), rb(), '0);
    cur_rst = 1'b0;
  endtask

  task automatic trap_hold(input int n);
    outs_t o = '0;
    o.exc = 1'b1;
    for (int k = 0; k < n; k++) step(rb(), rb(), o);
  endtask

  // zf < 0 means random Z in EXE, otherwise Z is forced to zf.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input int ifw,
                           input int memw, input int zf, output int cycles);
    info_t d;
    outs_t o;
    logic  z, tk;
    d = classify(op, func);
    cycles = 0;
    cur_op = op; cur_func = func;
    for (int k = 0; k < ifw; k++) begin
      o = '0; o.mreq = 1'b1; step(1'b0, rb(), o); cycles++;
    end
    o = '0; o.mreq = 1'b1; o.irwr = 1'b1; o.pcwr = 1'b1;
    step(1'b1, rb(), o); cycles++;
    o = '0;
    if (d.j) begin
      o.pcwr = 1'b1; o.pcsrc = 2'b10; o.retire = 1'b1;
      step(rb(), rb(), o); cycles++;
      return;
    end
    step(rb(), rb(), o); cycles++;
    if (!d.legal) return;
    z = (zf < 0) ? rb() : 1'(zf);
    o.aluc = ALUC_W'(d.aluc);
    o.aluqb = d.rtype | d.beq | d.bne;
    o.se = !d.imm_zero;
    if (d.beq | d.bne) begin
      tk = (d.beq & z) | (d.bne & !z);
      o.pcwr = tk; o.pcsrc = tk ? 2'b01 : 2'b00; o.retire = 1'b1;
      step(rb(), z, o); cycles++;
      return;
    end
    step(rb(), z, o); cycles++;
    if (d.lw | d.sw) begin
      o = '0; o.mreq = 1'b1; o.msel = 1'b1; o.wmem = d.sw;
      for (int k = 0; k < memw; k++) begin step(1'b0, rb(), o); cycles++; end
      o.retire = d.sw;
      step(1'b1, rb(), o); cycles++;
      if (d.sw) return;
    end
    o = '0; o.wreg = 1'b1; o.regrt = !d.rtype; o.reg2reg = d.lw; o.retire = 1'b1;
    step(rb(), rb(), o); cycles++;
  endtask

  logic [11:0] legal_tab [12] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h2a},
    {6'h08, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
    {6'h04, 6'h00}, {6'h05, 6'h00}
  };

  initial begin
    int cyc;
    logic [5:0] op, fn;
    info_t d;
    do_reset();

    run_instr(6'h00, 6'h20, 0, 0, -1, cyc);
    check("add_cycles", 32'(cyc), 32'd4);
    check("add_count", 32'(model_cnt), 32'd1);
    run_instr(6'h23, 6'h11, 0, 2, -1, cyc);
    check("lw_wait_cycles", 32'(cyc), 32'd7);
    run_instr(6'h04, 6'h00, 0, 0, 1, cyc);
    check("beq_cycles", 32'(cyc), 32'd3);
    run_instr(6'h05, 6'h00, 0, 0, 1, cyc);
    check("bne_cycles", 32'(cyc), 32'd3);
    run_instr(6'h02, 6'h3f, 0, 0, -1, cyc);
    check("j_cycles", 32'(cyc), 32'd2);
    run_instr(6'h2b, 6'h00, 0, 0, -1, cyc);
    check("sw_cycles", 32'(cyc), 32'd4);
    run_instr(6'h23, 6'h00, 0, 0, -1, cyc);
    check("lw_cycles", 32'(cyc), 32'd5);
    check("count_before_trap", 32'(model_cnt), 32'd7);

    run_instr(6'h3f, 6'h00, 1, 0, -1, cyc);
    trap_hold(10);
    check("count_after_trap", 32'(model_cnt), 32'd7);
    do_reset();

    for (int k = 0; k < 16; k++) run_instr(6'h0d, 6'(k), k % 3, 0, -1, cyc);
    check("wrap_count", 32'(model_cnt), 32'd0);
    run_instr(6'h00, 6'h2a, 0, 0, -1, cyc);

    // Reset in the middle of a fetch wait: the request must drop in the reset cycle.
    cur_op = 6'h08; cur_func = 6'h00;
    step(1'b0, 1'b0, outs_t'({1'b1, 17'b0}));
    step(1'b0, 1'b0, outs_t'({1'b1, 17'b0}));
    do_reset();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        op = 6'($urandom); fn = 6'($urandom);
      end else begin
        op = legal_tab[$urandom_range(0, 11)][11:6];
        fn = legal_tab[$urandom_range(0, 11)][5:0];
        if (op == 6'h00) fn = legal_tab[$urandom_range(0, 4)][5:0];
      end
      d = classify(op, fn);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), -1, cyc);
      if (!d.legal) begin
        trap_hold(3);
        do_reset();
      end
    end

    @(negedge Clk);
    #1;
    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_conunit.md
# multicycle_conunit

Multi-cycle control unit for the MIPS-subset CPU: a state machine that sequences each instruction through fetch, decode, execute, memory and write-back, driving the datapath's enables and multiplexer selects. It is the successor to the single-cycle control decoder. Added features: a shared memory port with a request/ready handshake, a parametrised ALU-control width, `slt`, illegal-instruction trapping, and a retired-instruction counter. It sits between the instruction register and the datapath and memory interface.

## Interface
- ALUC_W, 3, width of Aluc (≥3); upper bits above bit 2 always 0
- CNT_W, 32, width of the retired-instruction counter
- Clk  in  1  clock, rising edge
- Rst  in  1  reset; synchronous and active-high
- Op  in  6  IR[31:26]; valid from ID onward
- Func  in  6  IR[5:0]
- Z  in  1  ALU zero flag, sampled in EXE
- Mrdy  in  1  memory ready; ignored when Mreq=0
- Mreq  out  1  memory request
- Msel  out  1  0 = instruction address (PC), 1 = data address (ALU result register)
- Wmem  out  1  memory write (store); valid with Mreq
- Irwr  out  1  IR load enable
- Pcwr  out  1  PC write enable
- Pcsrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- Regrt  out  1  destination register is rt (1) or rd (0)
- Se  out  1  sign-extend (1) or zero-extend (0) the immediate
- Aluqb  out  1  ALU B operand: 1 = register qb, 0 = immediate
- Aluc  out  ALUC_W  000 add, 001 sub, 010 and, 011 or, 100 slt
- Wreg  out  1  register-file write enable
- Reg2reg  out  1  write-back source: 1 = memory data, 0 = ALU
- Retire  out  1  one-cycle pulse on an instruction's last cycle
- Icnt  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W
- Exc  out  1  illegal-instruction trap; sticky

## Operation
- States: IF, ID, EXE, MEM, WB, TRAP.
- IF:
  - Mreq=1, Msel=0.
  - On Mrdy: Irwr=1, Pcwr=1 (Pcsrc=00), go to ID. Otherwise stay in IF.
- ID: decode Op/Func.
  - j (000010): Pcwr=1, Pcsrc=10, Retire, go to IF.
  - Undefined encoding: go to TRAP.
  - All other instructions: go to EXE.
- Supported encodings:
  - R-type (Op=0) with Func add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101.
- EXE:
  - Aluc: R-type by Func; addi/lw/sw → add; andi → and; ori → or; beq/bne → sub.
  - Aluqb=1 for R-type, beq and bne.
  - Se=0 for andi/ori, 1 otherwise.
  - beq/bne: if (beq&Z)|(bne&~Z), then Pcwr=1, Pcsrc=01. Retire, go to IF.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - Mreq=1, Msel=1, Wmem=sw.
  - On Mrdy: sw → Retire, go to IF; lw → go to WB. Otherwise stay in MEM.
- WB:
  - Wreg=1.
  - Regrt=1 for all I-type; Reg2reg=lw.
  - Retire, go to IF.
- TRAP: Exc=1; all enables 0; held until Rst.
- Outputs not listed for a state are 0.
- Icnt increments on every Retire cycle.

## Timing
- Rst high:
  - Next state IF, Icnt=0, Exc=0.
  - All outputs forced 0 in the reset cycle, including Mreq.
  - First fetch request appears in the first cycle after Rst falls.
- Outputs are combinational from state, Op/Func, Z and Mrdy. Irwr, Pcwr (IF) and the MEM-exit Retire are Mrdy-gated.
- With zero-wait memory (Mrdy=1 whenever Mreq=1), cycles per instruction: j 2, beq/bne 3, sw 4, R-type/addi/andi/ori 4, lw 5.
- Each Mrdy-low cycle in IF or MEM adds one cycle. Mreq, Msel and Wmem are held stable while waiting.
- Rst mid-wait (IF or MEM): the request is abandoned immediately; no Irwr/Wmem effect after the reset cycle.
- Icnt at all-ones plus a Retire → 0; no flag.

## Structure
- Package conunit_pkg:
  - Opcode and Func localparams.
  - State enum.
  - Aluc encodings.
  - Pcsrc encodings.
- Sub-module conunit_decode: combinational Op/Func → instruction one-hots plus an illegal flag.
- FSM, output logic and counter live in multicycle_conunit.

## Test plan
- Reset, then `add` (Op=0, Func=100000), Mrdy tied 1 → states IF,ID,EXE,WB. WB has Wreg=1, Regrt=0. Retire at cycle 4, Icnt=1.
- `lw` with Mrdy low for 2 cycles in MEM → MEM lasts 3 cycles with Mreq=1, Msel=1, Wmem=0. WB has Reg2reg=1, Regrt=1. Total 7 cycles.
- `beq` with Z=1 → EXE shows Aluc=001, Pcwr=1, Pcsrc=01. `bne` with Z=1 → Pcwr=0. Both retire in 3 cycles.
- `j` → ID shows Pcwr=1, Pcsrc=10, Retire. Next cycle is IF.
- Op=111111 → TRAP with Exc=1, all enables 0 for 10 cycles, Icnt unchanged. Rst → Exc=0, state IF.
- CNT_W=4, 16 retired `ori` (Aluc=011, Se=0) → Icnt wraps to 0. Rst asserted during an IF wait → Mreq=0 that cycle, Icnt=0.
